// File: rtl/rl11_dma_pkg.sv
// Shared definitions for the RL11 NPR data-transfer engine: FSM states, ARM
// register map, status bit positions and Unibus cycle codes.
package rl11_dma_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        WAITF = 4'd1,
        REQ   = 4'd2,
        SACK  = 4'd3,
        SETUP = 4'd4,
        MSYN  = 4'd5,
        ENDC  = 4'd6
    } state_e;

    localparam logic [2:0] REG_ID   = 3'd0;
    localparam logic [2:0] REG_CTL  = 3'd1;
    localparam logic [2:0] REG_WC   = 3'd2;
    localparam logic [2:0] REG_FIFO = 3'd3;
    localparam logic [2:0] REG_STAT = 3'd4;

    localparam logic [31:0] ID_WORD = 32'h524D2005;

    localparam int CTL_GO    = 31;
    localparam int CTL_ABORT = 30;
    localparam int CTL_DIR   = 29;

    localparam int ST_BUSY    = 31;
    localparam int ST_DONE    = 30;
    localparam int ST_NXM     = 29;
    localparam int ST_OVF     = 28;
    localparam int ST_ABORTED = 27;

    localparam logic [1:0] DATI = 2'b00;
    localparam logic [1:0] DATO = 2'b10;

endpackage

// File: rtl/rl11_dma_fifo.sv
// Word FIFO between the ARM and the Unibus side; head word is readable
// combinationally so it can be placed on the bus without an extra cycle.
module rl11_dma_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop frees a slot on the same clock, so push into a full FIFO is legal then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rl11_dma.sv
// RL11 Unibus NPR engine: moves one word per grant between PDP memory and the
// ARM-side FIFO, reporting completion and non-existent-memory errors.
module rl11_dma #(
    parameter int DESKEW    = 2,
    parameter int TIMEOUT   = 500,
    parameter int FIFODEPTH = 16
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armwaddr,
    input  logic [2:0]  armraddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        armrstrobe,
    output logic        armintrq,
    input  logic        init_in_h,
    output logic        npr_out_h,
    input  logic        npg_in_h,
    output logic        sack_out_h,
    output logic        bbsy_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        msyn_out_h,
    input  logic        ssyn_in_h,
    input  logic [15:0] d_in_h
);
    import rl11_dma_pkg::*;

    localparam int CW = $clog2(FIFODEPTH) + 1;
    localparam logic [15:0] DESKEW_LAST  = 16'(DESKEW - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [17:0] ba_q, ba_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d, nxm_q, nxm_d, ovf_q, ovf_d;
    logic        aborted_q, aborted_d, abort_q, abort_d;

    logic        npr_q, npr_d, sack_q, sack_d, bbsy_q, bbsy_d, msyn_q, msyn_d;
    logic [17:0] a_q, a_d;
    logic [1:0]  c_q, c_d;
    logic [15:0] d_q, d_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [15:0]   fifo_wdata, fifo_rdata;
    logic [CW-1:0] fifo_count;

    logic busy, wr_ctl, wr_wc, wr_fifo, wr_stat, go, abort_req;
    logic bus_push, bus_pop, arm_pop, ovf_event;
    logic unused_wdata;

    assign busy      = (state_q != IDLE);
    assign wr_ctl    = armwrite && (armwaddr == REG_CTL);
    assign wr_wc     = armwrite && (armwaddr == REG_WC);
    assign wr_fifo   = armwrite && (armwaddr == REG_FIFO);
    assign wr_stat   = armwrite && (armwaddr == REG_STAT);
    assign go        = wr_ctl && armwdata[CTL_GO] && !busy;
    assign abort_req = wr_ctl && armwdata[CTL_ABORT] && busy;
    assign unused_wdata = ^armwdata[28:18];

    // Bus side wins the single FIFO port; a colliding ARM push is lost and flagged.
    assign bus_push   = (state_q == MSYN) && ssyn_in_h && dir_q;
    assign bus_pop    = (state_q == MSYN) && ssyn_in_h && !dir_q;
    assign arm_pop    = armrstrobe && (armraddr == REG_FIFO) && !fifo_empty;
    assign fifo_push  = bus_push || wr_fifo;
    assign fifo_pop   = bus_pop || arm_pop;
    assign fifo_wdata = bus_push ? d_in_h : armwdata[15:0];
    assign ovf_event  = (bus_push && wr_fifo) || (fifo_push && fifo_full && !fifo_pop);

    rl11_dma_fifo #(.DEPTH(FIFODEPTH), .CW(CW)) u_fifo (
        .clk   (CLOCK),
        .rst   (RESET),
        .clr   (init_in_h),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            ba_q      <= '0;
            wc_q      <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            nxm_q     <= 1'b0;
            ovf_q     <= 1'b0;
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
            npr_q     <= 1'b0;
            sack_q    <= 1'b0;
            bbsy_q    <= 1'b0;
            msyn_q    <= 1'b0;
            a_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            ba_q      <= ba_d;
            wc_q      <= wc_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
            nxm_q     <= nxm_d;
            ovf_q     <= ovf_d;
            aborted_q <= aborted_d;
            abort_q   <= abort_d;
            npr_q     <= npr_d;
            sack_q    <= sack_d;
            bbsy_q    <= bbsy_d;
            msyn_q    <= msyn_d;
            a_q       <= a_d;
            c_q       <= c_d;
            d_q       <= d_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ba_d      = ba_q;
        wc_d      = wc_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        done_d    = done_q;
        nxm_d     = nxm_q;
        ovf_d     = ovf_q;
        aborted_d = aborted_q;
        abort_d   = abort_q;
        if (wr_stat && armwdata[ST_BUSY]) begin
            done_d    = 1'b0;
            nxm_d     = 1'b0;
            ovf_d     = 1'b0;
            aborted_d = 1'b0;
        end
        if (ovf_event) ovf_d = 1'b1;
        if (wr_ctl && !busy) begin
            dir_d = armwdata[CTL_DIR];
            ba_d  = armwdata[17:0];
        end
        if (wr_wc && !busy) wc_d = armwdata[15:0];
        case (state_q)
            IDLE: begin
                if (go) begin
                    if (wc_q != '0) state_d = WAITF;
                    else            done_d  = 1'b1;
                end
            end
            WAITF: begin
                if (abort_req || abort_q) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (dir_q ? !fifo_full : !fifo_empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (abort_req || abort_q) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (npg_in_h) begin
                    state_d = SACK;
                end
            end
            SACK: begin
                cnt_d   = '0;
                state_d = SETUP;
            end
            SETUP: begin
                if (cnt_q == DESKEW_LAST) begin
                    cnt_d   = '0;
                    state_d = MSYN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            MSYN: begin
                if (ssyn_in_h) begin
                    ba_d    = ba_q + 18'd2;
                    wc_d    = wc_q - 16'd1;
                    state_d = ENDC;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    nxm_d   = 1'b1;
                    state_d = ENDC;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ENDC: begin
                if (!ssyn_in_h) begin
                    if (nxm_q) begin
                        state_d = IDLE;
                    end else if (wc_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (abort_q) begin
                        aborted_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = WAITF;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Aborts arriving once the bus is owned wait for the cycle to finish.
        if (abort_req && (state_q inside {SACK, SETUP, MSYN, ENDC})) abort_d = 1'b1;
        if (state_d == IDLE) abort_d = 1'b0;
        if (init_in_h) begin
            state_d   = IDLE;
            cnt_d     = '0;
            done_d    = 1'b0;
            nxm_d     = 1'b0;
            ovf_d     = 1'b0;
            aborted_d = busy;
            abort_d   = 1'b0;
        end
    end

    // Bus outputs are registered from the next state so they move with it.
    always_comb begin
        npr_d  = (state_d == REQ);
        sack_d = (state_d == SACK);
        bbsy_d = (state_d inside {SACK, SETUP, MSYN, ENDC});
        msyn_d = (state_d == MSYN);
        a_d    = '0;
        c_d    = '0;
        d_d    = '0;
        if (state_d == SACK) begin
            a_d = ba_q;
            c_d = dir_q ? DATI : DATO;
            d_d = dir_q ? 16'd0 : fifo_rdata;
        end else if (bbsy_d) begin
            a_d = a_q;
            c_d = c_q;
            d_d = d_q;
        end
    end

    assign npr_out_h  = npr_q;
    assign sack_out_h = sack_q;
    assign bbsy_out_h = bbsy_q;
    assign msyn_out_h = msyn_q;
    assign a_out_h    = a_q;
    assign c_out_h    = c_q;
    assign d_out_h    = d_q;
    assign armintrq   = done_q || nxm_q;

    always_comb begin
        armrdata = '0;
        case (armraddr)
            REG_ID:   armrdata = ID_WORD;
            REG_CTL:  armrdata = {2'b00, dir_q, 11'd0, ba_q};
            REG_WC:   armrdata = {16'd0, wc_q};
            REG_FIFO: armrdata = fifo_empty ? 32'd0 : {16'd0, fifo_rdata};
            REG_STAT: begin
                armrdata[ST_BUSY]    = busy;
                armrdata[ST_DONE]    = done_q;
                armrdata[ST_NXM]     = nxm_q;
                armrdata[ST_OVF]     = ovf_q;
                armrdata[ST_ABORTED] = aborted_q;
                armrdata[16 +: CW]   = fifo_count;
                armrdata[3:0]        = state_q;
            end
            default:  armrdata = '0;
        endcase
    end

endmodule

// File: tb/tb_rl11_dma.sv
// Directed bench for rl11_dma: a Unibus memory slave and grant arbiter model
// around the DUT, with hand-computed expectations for each scenario.
`timescale 1ns/1ps
module tb_rl11_dma;
    logic        CLOCK;
    logic        RESET;
    logic        armwrite;
    logic [2:0]  armwaddr;
    logic [2:0]  armraddr;
    logic [31:0] armwdata;
    logic [31:0] armrdata;
    logic        armrstrobe;
    logic        armintrq;
    logic        init_in_h;
    logic        npr_out_h;
    logic        npg_in_h;
    logic        sack_out_h;
    logic        bbsy_out_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        msyn_out_h;
    logic        ssyn_in_h;
    logic [15:0] d_in_h;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem [logic [17:0]];
    logic        slave_en    = 1'b1;
    int          slave_delay = 0;
    int          slave_wait  = 0;
    logic        grant_en    = 1'b1;
    int          dato_cnt    = 0;
    logic [17:0] last_addr   = '0;
    logic [15:0] last_data   = '0;
    int          sack_cnt    = 0;
    logic        sack_prev   = 1'b0;
    int          msyn_run    = 0;
    int          msyn_len    = 0;
    int          setup_run   = 0;
    logic        seen_msyn   = 1'b0;
    int          min_setup   = 1000;

    rl11_dma dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .armwrite   (armwrite),
        .armwaddr   (armwaddr),
        .armraddr   (armraddr),
        .armwdata   (armwdata),
        .armrdata   (armrdata),
        .armrstrobe (armrstrobe),
        .armintrq   (armintrq),
        .init_in_h  (init_in_h),
        .npr_out_h  (npr_out_h),
        .npg_in_h   (npg_in_h),
        .sack_out_h (sack_out_h),
        .bbsy_out_h (bbsy_out_h),
        .a_out_h    (a_out_h),
        .c_out_h    (c_out_h),
        .d_out_h    (d_out_h),
        .msyn_out_h (msyn_out_h),
        .ssyn_in_h  (ssyn_in_h),
        .d_in_h     (d_in_h)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
            $display("ok   %s: %h", tag, actual);
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic arm_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge CLOCK);
        armwaddr = addr;
        armwdata = data;
        armwrite = 1'b1;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic arm_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge CLOCK);
        armraddr = addr;
        #1 data = armrdata;
    endtask

    task automatic arm_pop(output logic [31:0] data);
        @(negedge CLOCK);
        armraddr = 3'd3;
        #1 data = armrdata;
        armrstrobe = 1'b1;
        @(negedge CLOCK);
        armrstrobe = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [31:0] v;
        int n;
        n = 0;
        armraddr = 3'd4;
        do begin
            @(negedge CLOCK);
            #1 v = armrdata;
            n++;
        end while (v[31] && n < budget);
        check_value({tag, " idle"}, {31'd0, v[31]}, 32'd0);
    endtask

    task automatic wait_msyn(input string tag);
        int n;
        n = 0;
        while (!msyn_out_h && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        check_value({tag, " msyn"}, {31'd0, msyn_out_h}, 32'd1);
    endtask

    // Arbiter: grants whenever requested and enabled.
    initial begin
        npg_in_h = 1'b0;
        forever begin
            @(negedge CLOCK);
            npg_in_h = npr_out_h && grant_en;
        end
    end

    // Memory slave: answers MSYN after slave_delay clocks unless disabled.
    initial begin
        ssyn_in_h = 1'b0;
        d_in_h    = '0;
        forever begin
            @(negedge CLOCK);
            if (msyn_out_h) begin
                if (!ssyn_in_h && slave_en) begin
                    if (slave_wait >= slave_delay) begin
                        if (c_out_h == 2'b00) begin
                            d_in_h = mem.exists(a_out_h) ? mem[a_out_h] : 16'h0000;
                        end else begin
                            mem[a_out_h] = d_out_h;
                            last_addr    = a_out_h;
                            last_data    = d_out_h;
                            dato_cnt++;
                        end
                        ssyn_in_h = 1'b1;
                    end else begin
                        slave_wait++;
                    end
                end
            end else begin
                ssyn_in_h  = 1'b0;
                slave_wait = 0;
            end
        end
    end

    // Bus monitor: SACK pulses, MSYN width, address-to-MSYN setup time.
    initial begin
        forever begin
            @(posedge CLOCK);
            #1;
            if (sack_out_h && !sack_prev) sack_cnt++;
            sack_prev = sack_out_h;
            if (msyn_out_h) begin
                msyn_run++;
            end else if (msyn_run != 0) begin
                msyn_len = msyn_run;
                msyn_run = 0;
            end
            if (!bbsy_out_h) begin
                setup_run = 0;
                seen_msyn = 1'b0;
            end else if (!msyn_out_h && !seen_msyn) begin
                setup_run++;
            end else if (msyn_out_h && !seen_msyn) begin
                seen_msyn = 1'b1;
                if (setup_run < min_setup) min_setup = setup_run;
            end
        end
    end

    initial begin
        logic [31:0] v;
        int n;
        RESET      = 1'b1;
        armwrite   = 1'b0;
        armwaddr   = '0;
        armraddr   = '0;
        armwdata   = '0;
        armrstrobe = 1'b0;
        init_in_h  = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        check_value("rst ctl", {26'd0, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h}, 32'd0);
        check_value("rst a", {14'd0, a_out_h}, 32'd0);
        check_value("rst d", {16'd0, d_out_h}, 32'd0);
        check_value("rst intrq", {31'd0, armintrq}, 32'd0);
        arm_read(3'd4, v); check_value("rst status", v, 32'h0000_0000);
        arm_read(3'd0, v); check_value("id", v, 32'h524D_2005);

        // DATI of three words from 18'o001000
        mem[18'o001000] = 16'd1;
        mem[18'o001002] = 16'd2;
        mem[18'o001004] = 16'd3;
        arm_write(3'd2, 32'd3);
        arm_write(3'd1, 32'hA000_0200);
        wait_idle("t1", 300);
        arm_read(3'd4, v); check_value("t1 status", v, 32'h4003_0000);
        check_value("t1 intrq", {31'd0, armintrq}, 32'd1);
        arm_read(3'd1, v); check_value("t1 ba", v, 32'h2000_0206);
        arm_read(3'd2, v); check_value("t1 wc", v, 32'd0);
        arm_pop(v); check_value("t1 pop0", v, 32'd1);
        arm_pop(v); check_value("t1 pop1", v, 32'd2);
        arm_pop(v); check_value("t1 pop2", v, 32'd3);
        arm_pop(v); check_value("t1 pop empty", v, 32'd0);
        arm_read(3'd4, v); check_value("t1 drained", v, 32'h4000_0000);
        arm_write(3'd4, 32'h8000_0000);
        #1 check_value("t1 intrq cleared", {31'd0, armintrq}, 32'd0);

        // DATO of one word at the top of the address space
        dato_cnt = 0;
        arm_write(3'd3, 32'h0000_A72E);
        arm_write(3'd2, 32'd1);
        arm_write(3'd1, 32'h8003_FFFE);
        wait_idle("t2", 300);
        check_value("t2 dato count", dato_cnt, 32'd1);
        check_value("t2 addr", {14'd0, last_addr}, 32'h0003_FFFE);
        check_value("t2 data", {16'd0, last_data}, 32'h0000_A72E);
        arm_read(3'd1, v); check_value("t2 ba wrap", v, 32'h0000_0000);
        arm_read(3'd4, v); check_value("t2 status", v, 32'h4000_0000);
        arm_write(3'd4, 32'h8000_0000);

        // DATI to unmapped memory: NXM after TIMEOUT clocks of MSYN
        slave_en = 1'b0;
        msyn_len = 0;
        arm_write(3'd2, 32'd2);
        arm_write(3'd1, 32'hA000_7000);
        wait_idle("t3", 1000);
        check_value("t3 msyn len", msyn_len, 32'd500);
        arm_read(3'd4, v); check_value("t3 status", v, 32'h2000_0000);
        check_value("t3 intrq", {31'd0, armintrq}, 32'd1);
        arm_read(3'd1, v); check_value("t3 ba kept", v, 32'h2000_7000);
        arm_read(3'd2, v); check_value("t3 wc kept", v, 32'd2);
        check_value("t3 bbsy", {31'd0, bbsy_out_h}, 32'd0);
        arm_write(3'd4, 32'h8000_0000);
        slave_en = 1'b1;

        // DATO with empty FIFO: holds in WAITF until words arrive
        dato_cnt  = 0;
        sack_cnt  = 0;
        min_setup = 1000;
        arm_write(3'd2, 32'd4);
        arm_write(3'd1, 32'h8000_0400);
        repeat (20) @(negedge CLOCK);
        check_value("t4 npr idle", {31'd0, npr_out_h}, 32'd0);
        arm_read(3'd4, v); check_value("t4 waitf", v, 32'h8000_0001);
        arm_write(3'd3, 32'h1111);
        arm_write(3'd3, 32'h2222);
        arm_write(3'd3, 32'h3333);
        arm_write(3'd3, 32'h4444);
        wait_idle("t4", 400);
        check_value("t4 dato count", dato_cnt, 32'd4);
        check_value("t4 grants", sack_cnt, 32'd4);
        check_value("t4 last addr", {14'd0, last_addr}, 32'h0000_0406);
        check_value("t4 last data", {16'd0, last_data}, 32'h0000_4444);
        check_value("t4 mem 402", {16'd0, mem[18'h00402]}, 32'h0000_2222);
        check_value("t4 deskew", {31'd0, (min_setup >= 2)}, 32'd1);
        arm_read(3'd4, v); check_value("t4 status", v, 32'h4000_0000);
        arm_read(3'd1, v); check_value("t4 ba", v, 32'h0000_0408);
        arm_write(3'd4, 32'h8000_0000);

        // ABORT during MSYN: the cycle completes, then the transfer stops
        slave_delay = 10;
        arm_write(3'd2, 32'd5);
        arm_write(3'd1, 32'hA000_0600);
        wait_msyn("t5");
        arm_write(3'd1, 32'h4000_0000);
        wait_idle("t5", 300);
        arm_read(3'd2, v); check_value("t5 wc", v, 32'd4);
        arm_read(3'd4, v); check_value("t5 status", v, 32'h0801_0000);
        arm_read(3'd1, v); check_value("t5 ba", v, 32'h2000_0602);
        arm_write(3'd4, 32'h8000_0000);

        // RESET mid-MSYN clears the bus outputs without waiting for a clock
        arm_write(3'd2, 32'd2);
        arm_write(3'd1, 32'hA000_0600);
        wait_msyn("t5r");
        @(negedge CLOCK);
        #1 RESET = 1'b1;
        #1;
        check_value("t5r ctl", {26'd0, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, c_out_h}, 32'd0);
        check_value("t5r a", {14'd0, a_out_h}, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0;
        slave_delay = 0;
        arm_read(3'd4, v); check_value("t5r status", v, 32'h0000_0000);
        arm_read(3'd1, v); check_value("t5r ba", v, 32'h0000_0000);
        arm_read(3'd2, v); check_value("t5r wc", v, 32'd0);

        // FIFO overflow, then a same-clock bus pop and ARM push
        for (int i = 0; i < 16; i++) arm_write(3'd3, 32'h0100 + i);
        arm_read(3'd4, v); check_value("t6 full", v, 32'h0010_0000);
        arm_write(3'd3, 32'hDEAD);
        arm_read(3'd4, v); check_value("t6 ovf", v, 32'h1010_0000);
        arm_write(3'd4, 32'h8000_0000);
        dato_cnt = 0;
        arm_write(3'd2, 32'd1);
        arm_write(3'd1, 32'h8000_0800);
        n = 0;
        while (!ssyn_in_h && n < 200) begin
            @(negedge CLOCK);
            #1 n++;
        end
        check_value("t6 ssyn seen", {31'd0, ssyn_in_h}, 32'd1);
        armwaddr = 3'd3;
        armwdata = 32'hBEEF;
        armwrite = 1'b1;
        @(negedge CLOCK);
        armwrite = 1'b0;
        wait_idle("t6", 300);
        arm_read(3'd4, v); check_value("t6 same clock", v, 32'h4010_0000);
        check_value("t6 data", {16'd0, last_data}, 32'h0000_0100);
        arm_pop(v); check_value("t6 head", v, 32'h0000_0101);
        arm_write(3'd4, 32'h8000_0000);

        // INIT while waiting for a grant: aborts, keeps BA/WC/DIR, empties FIFO
        grant_en = 1'b0;
        arm_write(3'd2, 32'd3);
        arm_write(3'd1, 32'h8000_0100);
        repeat (5) @(negedge CLOCK);
        check_value("t7 npr", {31'd0, npr_out_h}, 32'd1);
        arm_read(3'd4, v); check_value("t7 req", v, 32'h800F_0002);
        @(negedge CLOCK);
        init_in_h = 1'b1;
        @(negedge CLOCK);
        init_in_h = 1'b0;
        #1 check_value("t7 npr init", {31'd0, npr_out_h}, 32'd0);
        arm_read(3'd4, v); check_value("t7 status", v, 32'h0800_0000);
        arm_read(3'd2, v); check_value("t7 wc kept", v, 32'd3);
        arm_read(3'd1, v); check_value("t7 ba kept", v, 32'h0000_0100);
        grant_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
